sensor_config_seq: RTL and testbench
====================================

SENSOR_CONFIG_SEQ -- requirements
Module: sensor_config_seq

Interface
REQ-001 SHALL have parameter IDX_W, default 10: width of LUT index and size.
REQ-002 SHALL have parameter ENTRY_W, default 42: LUT entry width {dev_addr[7:0], addr_type, data_type, addr[15:0], data[15:0]}.
REQ-003 SHALL have parameter RD_BASE, default 570: first LUT index whose read data is captured.
REQ-004 SHALL have parameter RD_NUM, default 16, range 1..64: number of readback slots.
REQ-005 SHALL have parameter GAP_CYC, default 1000: idle cycles between transactions.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 65535: maximum cycles to wait for the engine's response.
REQ-007 SHALL have parameter MAX_RETRY, default 3: retries per entry (used only under CFG_NACK_RETRY_EN).
REQ-008 SHALL have port clk  in  1  system clock; all logic is on its rising edge.
REQ-009 SHALL have port rstn  in  1  asynchronous, active-low reset.
REQ-010 SHALL have port start  in  1  single-cycle pulse that re-runs the sequence.
REQ-011 SHALL have port lut_size  in  IDX_W  number of LUT entries.
REQ-012 SHALL have port lut_index  out  IDX_W  current LUT address; the LUT is combinational.
REQ-013 SHALL have port lut_data  in  ENTRY_W  entry at lut_index.
REQ-014 SHALL have port i2c_req  out  1  single-cycle transaction request.
REQ-015 SHALL have port i2c_cmd  out  ENTRY_W  registered entry; stable from i2c_req until the response.
REQ-016 SHALL have port i2c_ack  in  1  pulse: transaction completed OK.
REQ-017 SHALL have port i2c_nack  in  1  pulse: transaction failed.
REQ-018 SHALL have port i2c_rdata  in  8  read byte.
REQ-019 SHALL have port i2c_rdata_en  in  1  i2c_rdata valid.
REQ-020 SHALL have port busy  out  1  sequence in progress.
REQ-021 SHALL have port config_done  out  1  level; sequence finished without error.
REQ-022 SHALL have port config_err  out  1  level; sequence aborted.
REQ-023 SHALL have port err_index  out  IDX_W  index of the failing entry.
REQ-024 SHALL have port rd_bank  out  8*RD_NUM  readback bytes; slot k occupies bits [8k+7:8k].
REQ-025 SHALL have port rd_valid  out  RD_NUM  slot k captured during the current run.

Function
REQ-026 SHALL implement the FSM states IDLE, FETCH, ISSUE, WAIT, GAP, DONE, ERR.
REQ-027 SHALL leave IDLE on the first cycle after reset deassertion (auto-start), or on start while in DONE/ERR; start while busy SHALL be ignored.
REQ-028 SHALL, on entering a run, clear lut_index, rd_valid, config_done and config_err; rd_bank SHALL keep its old data.
REQ-029 SHALL go from IDLE to DONE when lut_size==0, with no i2c_req issued.
REQ-030 SHALL, in FETCH, register lut_data into i2c_cmd (1 cycle); ISSUE SHALL assert i2c_req for exactly 1 cycle, then enter WAIT.
REQ-031 SHALL, in WAIT: on i2c_ack go to GAP; on i2c_nack, or on TIMEOUT_CYC cycles without a response, perform failure handling; ack and nack in the same cycle SHALL be treated as nack.
REQ-032 SHALL capture i2c_rdata into slot (lut_index-RD_BASE) and set the matching rd_valid bit when i2c_rdata_en=1 and RD_BASE<=lut_index<RD_BASE+RD_NUM; outside that range the data SHALL be discarded.
REQ-033 SHALL count GAP_CYC cycles in GAP, then increment lut_index; if the new value equals lut_size, go to DONE, else to FETCH.
REQ-034 SHALL hold config_done=1 in DONE and config_err=1 in ERR; busy SHALL be 1 in FETCH/ISSUE/WAIT/GAP only.
REQ-035 SHALL go to ERR on failure, with err_index=lut_index and lut_index held.
REQ-036 SHALL use counter widths that cover GAP_CYC and TIMEOUT_CYC without wrap.

Reset
REQ-037 SHALL, on rstn=0, immediately set state=IDLE and zero lut_index, i2c_req, i2c_cmd, busy, config_done, config_err, err_index, rd_bank, rd_valid and all counters.
REQ-038 SHALL, if reset occurs mid-transaction, drop i2c_req at once; a late i2c_ack or i2c_rdata_en after reset SHALL be ignored until WAIT.

Configuration
REQ-039 SHALL, with macro CFG_NACK_RETRY_EN defined, return to ISSUE after a failure (after GAP_CYC wait) while retry count<MAX_RETRY, and go to ERR on failure MAX_RETRY+1; the retry count SHALL clear per entry.
REQ-040 SHALL, without CFG_NACK_RETRY_EN, go to ERR on the first failure; MAX_RETRY is unused.

Verification
REQ-041 SHALL cover: lut_size=4, engine acks each request after 10 cycles -> exactly 4 i2c_req pulses, lut_index 0..3, config_done=1, busy=0.
REQ-042 SHALL cover: RD_BASE=2, RD_NUM=2, lut_size=4, rdata_en with 0x56 at index 2 and 0x78 at index 3 -> rd_bank[7:0]=0x56, rd_bank[15:8]=0x78, rd_valid=2'b11.
REQ-043 SHALL cover: nack at index 1, macro undefined -> config_err=1, err_index=1, 2 requests total.
REQ-044 SHALL cover: macro defined, MAX_RETRY=3, nack twice then ack at index 1 -> config_done=1; nacks four times -> config_err=1, 4 requests at index 1.
REQ-045 SHALL cover: TIMEOUT_CYC=50, no response -> failure declared 50 cycles after i2c_req; lut_size=0 -> DONE with no i2c_req.
REQ-046 SHALL cover: start pulse in busy state -> ignored; start in DONE -> rerun and rd_valid cleared; rstn low mid-WAIT -> all outputs zero.

Source files
------------

// File: rtl/sensor_config_seq_if.sv
// Handshake bundle between the sensor configuration sequencer and the I2C
// transaction engine. The sequencer drives the request side (master); the
// engine answers with ack/nack pulses and optional read data (slave).
interface sensor_config_seq_if #(
    parameter int ENTRY_W = 42
);
    logic               i2c_req;
    logic [ENTRY_W-1:0] i2c_cmd;
    logic               i2c_ack;
    logic               i2c_nack;
    logic [7:0]         i2c_rdata;
    logic               i2c_rdata_en;

    modport master (
        output i2c_req,
        output i2c_cmd,
        input  i2c_ack,
        input  i2c_nack,
        input  i2c_rdata,
        input  i2c_rdata_en
    );

    modport slave (
        input  i2c_req,
        input  i2c_cmd,
        output i2c_ack,
        output i2c_nack,
        output i2c_rdata,
        output i2c_rdata_en
    );
endinterface

// File: rtl/sensor_config_seq.sv
// Sensor configuration sequencer: walks a combinational LUT of I2C commands,
// issues one transaction per entry, waits for the engine's response, spaces
// transactions by GAP_CYC idle cycles and captures read bytes for a window of
// LUT indices into a readback bank. Runs automatically after reset and again
// on a start pulse once the previous run has finished.
// Optional feature: define CFG_NACK_RETRY_EN to retry a failed entry up to
// MAX_RETRY times (after a GAP_CYC wait) before aborting the sequence.
module sensor_config_seq #(
    parameter int IDX_W       = 10,
    parameter int ENTRY_W     = 42,
    parameter int RD_BASE     = 570,
    parameter int RD_NUM      = 16,
    parameter int GAP_CYC     = 1000,
    parameter int TIMEOUT_CYC = 65535,
    parameter int MAX_RETRY   = 3
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [IDX_W-1:0]        lut_size,
    output logic [IDX_W-1:0]        lut_index,
    input  logic [ENTRY_W-1:0]      lut_data,
    sensor_config_seq_if.master     i2c,
    output logic                    busy,
    output logic                    config_done,
    output logic                    config_err,
    output logic [IDX_W-1:0]        err_index,
    output logic [8*RD_NUM-1:0]     rd_bank,
    output logic [RD_NUM-1:0]       rd_valid
);

    // Counters sized so the largest terminal value never wraps.
    localparam int GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);
    localparam int TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t              state_r;
    logic [IDX_W-1:0]    lut_index_r;
    logic                i2c_req_r;
    logic [ENTRY_W-1:0]  i2c_cmd_r;
    logic                busy_r;
    logic                config_done_r;
    logic                config_err_r;
    logic [IDX_W-1:0]    err_index_r;
    logic [8*RD_NUM-1:0] rd_bank_r;
    logic [RD_NUM-1:0]   rd_valid_r;
    logic [GAP_W-1:0]    gap_cnt_r;
    logic [TMO_W-1:0]    tmo_cnt_r;
`ifdef CFG_NACK_RETRY_EN
    localparam int RTY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RTY_W-1:0]    retry_cnt_r;
    logic                retry_pend_r;
`endif

    logic [IDX_W-1:0]    next_idx_s;
    logic                resp_ok_s;
    logic                resp_fail_s;

    assign lut_index    = lut_index_r;
    assign i2c.i2c_req  = i2c_req_r;
    assign i2c.i2c_cmd  = i2c_cmd_r;
    assign busy         = busy_r;
    assign config_done  = config_done_r;
    assign config_err   = config_err_r;
    assign err_index    = err_index_r;
    assign rd_bank      = rd_bank_r;
    assign rd_valid     = rd_valid_r;

    // Index of the entry that follows the current one.
    always_comb begin
        next_idx_s = lut_index_r + IDX_W'(1);
    end

    // Classify the engine's response while waiting; nack wins over ack and a
    // silent engine fails once the timeout budget is spent.
    always_comb begin
        resp_ok_s   = 1'b0;
        resp_fail_s = 1'b0;
        if (state_r == S_WAIT) begin
            if (i2c.i2c_nack) begin
                resp_fail_s = 1'b1;
            end else if (i2c.i2c_ack) begin
                resp_ok_s = 1'b1;
            end else if (tmo_cnt_r >= TMO_W'(TIMEOUT_CYC - 1)) begin
                resp_fail_s = 1'b1;
            end else begin
                resp_fail_s = 1'b0;
            end
        end else begin
            resp_ok_s   = 1'b0;
            resp_fail_s = 1'b0;
        end
    end

    // Sequencer FSM with registered outputs and readback capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= S_IDLE;
            lut_index_r   <= '0;
            i2c_req_r     <= 1'b0;
            i2c_cmd_r     <= '0;
            busy_r        <= 1'b0;
            config_done_r <= 1'b0;
            config_err_r  <= 1'b0;
            err_index_r   <= '0;
            rd_bank_r     <= '0;
            rd_valid_r    <= '0;
            gap_cnt_r     <= '0;
            tmo_cnt_r     <= '0;
`ifdef CFG_NACK_RETRY_EN
            retry_cnt_r   <= '0;
            retry_pend_r  <= 1'b0;
`endif
        end else begin
            // The request is a single-cycle pulse unless re-armed below.
            i2c_req_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    // Run entry: readback data in rd_bank deliberately survives.
                    lut_index_r  <= '0;
                    rd_valid_r   <= '0;
                    config_err_r <= 1'b0;
`ifdef CFG_NACK_RETRY_EN
                    retry_cnt_r  <= '0;
                    retry_pend_r <= 1'b0;
`endif
                    if (lut_size == '0) begin
                        state_r       <= S_DONE;
                        config_done_r <= 1'b1;
                        busy_r        <= 1'b0;
                    end else begin
                        state_r       <= S_FETCH;
                        config_done_r <= 1'b0;
                        busy_r        <= 1'b1;
                    end
                end
                S_FETCH: begin
                    i2c_cmd_r   <= lut_data;
                    i2c_req_r   <= 1'b1;
`ifdef CFG_NACK_RETRY_EN
                    retry_cnt_r <= '0;
`endif
                    state_r     <= S_ISSUE;
                end
                S_ISSUE: begin
                    // The request cycle counts as the first cycle of the timeout.
                    tmo_cnt_r <= TMO_W'(1);
                    state_r   <= S_WAIT;
                end
                S_WAIT: begin
                    if (i2c.i2c_rdata_en) begin
                        for (int k = 0; k < RD_NUM; k++) begin
                            if (32'(lut_index_r) == 32'(RD_BASE + k)) begin
                                rd_bank_r[8*k +: 8] <= i2c.i2c_rdata;
                                rd_valid_r[k]       <= 1'b1;
                            end
                        end
                    end
                    if (resp_fail_s) begin
`ifdef CFG_NACK_RETRY_EN
                        if (retry_cnt_r < RTY_W'(MAX_RETRY)) begin
                            retry_cnt_r  <= retry_cnt_r + RTY_W'(1);
                            retry_pend_r <= 1'b1;
                            gap_cnt_r    <= '0;
                            state_r      <= S_GAP;
                        end else begin
                            state_r      <= S_ERR;
                            config_err_r <= 1'b1;
                            err_index_r  <= lut_index_r;
                            busy_r       <= 1'b0;
                        end
`else
                        state_r      <= S_ERR;
                        config_err_r <= 1'b1;
                        err_index_r  <= lut_index_r;
                        busy_r       <= 1'b0;
`endif
                    end else if (resp_ok_s) begin
`ifdef CFG_NACK_RETRY_EN
                        retry_pend_r <= 1'b0;
`endif
                        gap_cnt_r <= '0;
                        state_r   <= S_GAP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt_r >= GAP_W'(GAP_CYC - 1)) begin
`ifdef CFG_NACK_RETRY_EN
                        if (retry_pend_r) begin
                            // Re-issue the same held command.
                            retry_pend_r <= 1'b0;
                            i2c_req_r    <= 1'b1;
                            state_r      <= S_ISSUE;
                        end else begin
                            lut_index_r <= next_idx_s;
                            if (next_idx_s == lut_size) begin
                                state_r       <= S_DONE;
                                config_done_r <= 1'b1;
                                busy_r        <= 1'b0;
                            end else begin
                                state_r <= S_FETCH;
                            end
                        end
`else
                        lut_index_r <= next_idx_s;
                        if (next_idx_s == lut_size) begin
                            state_r       <= S_DONE;
                            config_done_r <= 1'b1;
                            busy_r        <= 1'b0;
                        end else begin
                            state_r <= S_FETCH;
                        end
`endif
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                S_DONE, S_ERR: begin
                    if (start) begin
                        state_r       <= S_IDLE;
                        lut_index_r   <= '0;
                        rd_valid_r    <= '0;
                        config_done_r <= 1'b0;
                        config_err_r  <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r       <= S_IDLE;
                    busy_r        <= 1'b0;
                    config_done_r <= 1'b0;
                    config_err_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_config_seq.sv
// Self-checking bench for sensor_config_seq. A responder process models the
// I2C engine (per-index nack plan, read data plan, optional silence) and
// scoreboards every request against the expected LUT index and command.
module tb_sensor_config_seq;

    localparam int IDX_W   = 10;
    localparam int ENTRY_W = 42;
    localparam int RD_NUM  = 2;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                start = 1'b0;
    logic [IDX_W-1:0]    lut_size = '0;
    logic [IDX_W-1:0]    lut_index;
    logic [ENTRY_W-1:0]  lut_data;
    logic                busy, config_done, config_err;
    logic [IDX_W-1:0]    err_index;
    logic [8*RD_NUM-1:0] rd_bank;
    logic [RD_NUM-1:0]   rd_valid;

    logic [ENTRY_W-1:0]  lut_mem [0:15];

    logic       resp_ack = 1'b0, resp_nack = 1'b0, resp_rd_en = 1'b0;
    logic [7:0] resp_rdata = 8'h00;
    logic       stray_ack = 1'b0, stray_rd_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int gen      = 0;
    int req_cnt  = 0;
    int req_idx1 = 0;
    int last_req_cyc = 0;
    bit no_resp  = 1'b0;
    int plan_nacks [0:15];
    int attempts   [0:15];
    bit plan_rd_en [0:15];
    logic [7:0] plan_rd_data [0:15];
    int exp_q [$];

    sensor_config_seq_if #(.ENTRY_W(ENTRY_W)) bus ();

    assign bus.i2c_ack      = resp_ack | stray_ack;
    assign bus.i2c_nack     = resp_nack;
    assign bus.i2c_rdata    = stray_rd_en ? 8'hEE : resp_rdata;
    assign bus.i2c_rdata_en = resp_rd_en | stray_rd_en;
    assign lut_data         = lut_mem[lut_index[3:0]];

    sensor_config_seq #(
        .IDX_W(IDX_W), .ENTRY_W(ENTRY_W), .RD_BASE(2), .RD_NUM(RD_NUM),
        .GAP_CYC(5), .TIMEOUT_CYC(50), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .lut_size(lut_size),
        .lut_index(lut_index), .lut_data(lut_data), .i2c(bus),
        .busy(busy), .config_done(config_done), .config_err(config_err),
        .err_index(err_index), .rd_bank(rd_bank), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model and request scoreboard.
    initial begin : responder
        int idx;
        int g;
        int e;
        forever begin
            @(negedge clk);
            if (bus.i2c_req === 1'b1) begin
                req_cnt++;
                last_req_cyc = cyc;
                idx = int'(lut_index);
                if (idx == 1) req_idx1++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_req: got request at index %0d, expected none", idx);
                end else begin
                    e = exp_q.pop_front();
                    if (idx != e) begin
                        n_fail++;
                        $display("FAIL sb_req_index: got %0d, expected %0d", idx, e);
                    end
                    n_checks++;
                    if (bus.i2c_cmd !== lut_mem[idx[3:0]]) begin
                        n_fail++;
                        $display("FAIL sb_req_cmd: got %h, expected %h", bus.i2c_cmd, lut_mem[idx[3:0]]);
                    end
                end
                if (!no_resp && idx < 16) begin
                    g = gen;
                    for (int i = 0; i < 9; i++) begin
                        @(negedge clk);
                        if (gen != g) break;
                    end
                    if (gen == g) begin
                        attempts[idx]++;
                        if (attempts[idx] <= plan_nacks[idx]) resp_nack = 1'b1;
                        else resp_ack = 1'b1;
                        resp_rd_en = plan_rd_en[idx];
                        resp_rdata = plan_rd_data[idx];
                        @(negedge clk);
                        resp_ack = 1'b0;
                        resp_nack = 1'b0;
                        resp_rd_en = 1'b0;
                    end
                end
            end
        end
    end

    task automatic clear_plan();
        for (int i = 0; i < 16; i++) begin
            plan_nacks[i] = 0;
            attempts[i] = 0;
            plan_rd_en[i] = 1'b0;
            plan_rd_data[i] = 8'h00;
        end
        req_cnt = 0;
        req_idx1 = 0;
        no_resp = 1'b0;
        exp_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (config_done === 1'b1 || config_err === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (lut_index !== '0) begin n_fail++; $display("FAIL rst_lut_index: got %0d, expected 0", lut_index); end
        n_checks++; if (bus.i2c_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b, expected 0", bus.i2c_req); end
        n_checks++; if (bus.i2c_cmd !== '0) begin n_fail++; $display("FAIL rst_cmd: got %h, expected 0", bus.i2c_cmd); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        n_checks++; if (config_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, expected 0", config_done); end
        n_checks++; if (config_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b, expected 0", config_err); end
        n_checks++; if (err_index !== '0) begin n_fail++; $display("FAIL rst_err_index: got %0d, expected 0", err_index); end
        n_checks++; if (rd_bank !== '0) begin n_fail++; $display("FAIL rst_rd_bank: got %h, expected 0", rd_bank); end
        n_checks++; if (rd_valid !== '0) begin n_fail++; $display("FAIL rst_rd_valid: got %b, expected 0", rd_valid); end
    endtask

    task automatic test_basic();
        bit ok;
        clear_plan();
        lut_size = 10'd4;
        plan_rd_en[0] = 1'b1; plan_rd_data[0] = 8'h11;
        plan_rd_en[2] = 1'b1; plan_rd_data[2] = 8'h56;
        plan_rd_en[3] = 1'b1; plan_rd_data[3] = 8'h78;
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        @(negedge clk);
        rstn = 1'b1;
        wait_end(2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_finish: got no end, expected done within bound"); end
        n_checks++; if (req_cnt != 4) begin n_fail++; $display("FAIL basic_req_cnt: got %0d, expected 4", req_cnt); end
        n_checks++; if (config_done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b, expected 1", config_done); end
        n_checks++; if (config_err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b, expected 0", config_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b, expected 0", busy); end
        n_checks++; if (lut_index !== 10'd4) begin n_fail++; $display("FAIL basic_lut_index: got %0d, expected 4", lut_index); end
        n_checks++; if (rd_bank !== 16'h7856) begin n_fail++; $display("FAIL basic_rd_bank: got %h, expected 7856", rd_bank); end
        n_checks++; if (rd_valid !== 2'b11) begin n_fail++; $display("FAIL basic_rd_valid: got %b, expected 11", rd_valid); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_sb_left: got %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_rerun();
        bit ok;
        clear_plan();
        lut_size = 10'd4;
        plan_rd_en[2] = 1'b1; plan_rd_data[2] = 8'h9A;
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        pulse_start();
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rerun_busy: got %b, expected 1", busy); end
        n_checks++; if (rd_valid !== 2'b00) begin n_fail++; $display("FAIL rerun_rd_valid_clr: got %b, expected 00", rd_valid); end
        n_checks++; if (config_done !== 1'b0) begin n_fail++; $display("FAIL rerun_done_clr: got %b, expected 0", config_done); end
        pulse_start();
        wait_end(2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rerun_finish: got no end, expected done within bound"); end
        n_checks++; if (req_cnt != 4) begin n_fail++; $display("FAIL rerun_req_cnt: got %0d, expected 4", req_cnt); end
        n_checks++; if (config_done !== 1'b1) begin n_fail++; $display("FAIL rerun_done: got %b, expected 1", config_done); end
        n_checks++; if (rd_bank !== 16'h789A) begin n_fail++; $display("FAIL rerun_rd_bank: got %h, expected 789a", rd_bank); end
        n_checks++; if (rd_valid !== 2'b01) begin n_fail++; $display("FAIL rerun_rd_valid: got %b, expected 01", rd_valid); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rerun_sb_left: got %0d pending, expected 0", exp_q.size()); end
    endtask

`ifdef CFG_NACK_RETRY_EN
    task automatic test_retry();
        bit ok;
        clear_plan();
        lut_size = 10'd4;
        plan_nacks[1] = 2;
        exp_q = '{0, 1, 1, 1, 2, 3};
        pulse_start();
        wait_end(3000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL retry_ok_finish: got no end, expected done within bound"); end
        n_checks++; if (config_done !== 1'b1) begin n_fail++; $display("FAIL retry_ok_done: got %b, expected 1", config_done); end
        n_checks++; if (req_cnt != 6) begin n_fail++; $display("FAIL retry_ok_req_cnt: got %0d, expected 6", req_cnt); end
        clear_plan();
        plan_nacks[1] = 4;
        exp_q = '{0, 1, 1, 1, 1};
        pulse_start();
        wait_end(3000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL retry_err_finish: got no end, expected err within bound"); end
        n_checks++; if (config_err !== 1'b1) begin n_fail++; $display("FAIL retry_err: got %b, expected 1", config_err); end
        n_checks++; if (err_index !== 10'd1) begin n_fail++; $display("FAIL retry_err_index: got %0d, expected 1", err_index); end
        n_checks++; if (req_idx1 != 4) begin n_fail++; $display("FAIL retry_req_idx1: got %0d, expected 4", req_idx1); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL retry_sb_left: got %0d pending, expected 0", exp_q.size()); end
    endtask
`else
    task automatic test_nack();
        bit ok;
        clear_plan();
        lut_size = 10'd4;
        plan_nacks[1] = 1;
        exp_q = '{0, 1};
        pulse_start();
        wait_end(2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL nack_finish: got no end, expected err within bound"); end
        n_checks++; if (config_err !== 1'b1) begin n_fail++; $display("FAIL nack_err: got %b, expected 1", config_err); end
        n_checks++; if (config_done !== 1'b0) begin n_fail++; $display("FAIL nack_done: got %b, expected 0", config_done); end
        n_checks++; if (err_index !== 10'd1) begin n_fail++; $display("FAIL nack_err_index: got %0d, expected 1", err_index); end
        n_checks++; if (lut_index !== 10'd1) begin n_fail++; $display("FAIL nack_lut_index: got %0d, expected 1", lut_index); end
        n_checks++; if (req_cnt != 2) begin n_fail++; $display("FAIL nack_req_cnt: got %0d, expected 2", req_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nack_busy: got %b, expected 0", busy); end
    endtask
`endif

    task automatic test_timeout();
        bit ok;
        clear_plan();
        lut_size = 10'd4;
        no_resp = 1'b1;
        exp_q.push_back(0);
        pulse_start();
        wait_end(500, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo_finish: got no end, expected err within bound"); end
        n_checks++; if ((cyc - last_req_cyc) != 50) begin n_fail++; $display("FAIL tmo_latency: got %0d cycles, expected 50", cyc - last_req_cyc); end
        n_checks++; if (config_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b, expected 1", config_err); end
        n_checks++; if (err_index !== 10'd0) begin n_fail++; $display("FAIL tmo_err_index: got %0d, expected 0", err_index); end
        n_checks++; if (req_cnt != 1) begin n_fail++; $display("FAIL tmo_req_cnt: got %0d, expected 1", req_cnt); end
        no_resp = 1'b0;
    endtask

    task automatic test_zero_size();
        bit ok;
        clear_plan();
        lut_size = 10'd0;
        pulse_start();
        wait_end(50, ok);
        repeat (3) @(negedge clk);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_finish: got no end, expected done within bound"); end
        n_checks++; if (config_done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b, expected 1", config_done); end
        n_checks++; if (config_err !== 1'b0) begin n_fail++; $display("FAIL zero_err: got %b, expected 0", config_err); end
        n_checks++; if (req_cnt != 0) begin n_fail++; $display("FAIL zero_req_cnt: got %0d, expected 0", req_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        bit seen;
        clear_plan();
        lut_size = 10'd4;
        exp_q = '{0, 1};
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (req_idx1 == 1) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rmid_reach: got no request at index 1, expected one"); end
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        gen++;
        #1;
        n_checks++; if (bus.i2c_req !== 1'b0 || bus.i2c_cmd !== '0) begin n_fail++; $display("FAIL rmid_bus: got req %b cmd %h, expected 0", bus.i2c_req, bus.i2c_cmd); end
        n_checks++; if (lut_index !== '0 || err_index !== '0) begin n_fail++; $display("FAIL rmid_index: got %0d/%0d, expected 0/0", lut_index, err_index); end
        n_checks++; if ({busy, config_done, config_err} !== 3'b000) begin n_fail++; $display("FAIL rmid_status: got %b, expected 000", {busy, config_done, config_err}); end
        n_checks++; if (rd_bank !== '0 || rd_valid !== '0) begin n_fail++; $display("FAIL rmid_rd: got %h/%b, expected 0/0", rd_bank, rd_valid); end
        stray_ack = 1'b1;
        repeat (2) @(negedge clk);
        stray_ack = 1'b0;
        clear_plan();
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        rstn = 1'b1;
        @(negedge clk);
        stray_ack = 1'b1;
        stray_rd_en = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        stray_rd_en = 1'b0;
        wait_end(2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_finish: got no end, expected done within bound"); end
        n_checks++; if (config_done !== 1'b1) begin n_fail++; $display("FAIL rmid_done: got %b, expected 1", config_done); end
        n_checks++; if (req_cnt != 4) begin n_fail++; $display("FAIL rmid_req_cnt: got %0d, expected 4", req_cnt); end
        n_checks++; if (rd_valid !== 2'b00) begin n_fail++; $display("FAIL rmid_rd_valid: got %b, expected 00", rd_valid); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rmid_sb_left: got %0d pending, expected 0", exp_q.size()); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            lut_mem[i] = {8'(8'h20 + i), 1'b0, 1'b1, 16'(16'h3000 + i), 16'(16'hA500 ^ i)};
        end
        clear_plan();
        test_reset();
        test_basic();
        test_rerun();
`ifdef CFG_NACK_RETRY_EN
        test_retry();
`else
        test_nack();
`endif
        test_timeout();
        test_zero_size();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
